// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter for a single data memory port
//
// Parameters:
//   ADDR_W  address width of both requesters and the memory port
//   DATA_W  data width of both requesters and the memory port
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   m0_req/we/addr/wdata, m1_...         requester commands, held until gnt
//   m0_gnt, m1_gnt                       one-cycle pulse when the command is sampled
//   m0_rvalid, m1_rvalid                 one-cycle pulse when the access completes
//   m0_rdata, m1_rdata                   per-requester read result, valid with rvalid
//   mem_addr, mem_we, mem_wdata          command to the data memory
//   mem_rdata                            read data from the data memory
//
// Every transaction is IDLE (grant) -> BUSY (memory access) -> RESP (rvalid).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_owner;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              grant;
    logic              winner;

    // Winner selection: a lone requester always wins; on a tie the requester
    // that was not served last wins.
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~last_owner;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                // Grants are masked while reset is asserted so no gnt pulse
                // leaks out of a reset cycle with requests already pending.
                if ((m0_req || m1_req) && rst_n) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= winner;
                last_owner <= winner;
                lat_we     <= winner ? m1_we    : m0_we;
                lat_addr   <= winner ? m1_addr  : m0_addr;
                lat_wdata  <= winner ? m1_wdata : m0_wdata;
            end
            // Only the owner's response register is updated, so the other
            // requester's rdata keeps its previous value.
            if (state == BUSY) begin
                if (owner) begin
                    m1_rdata_q <= mem_rdata;
                end else begin
                    m0_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign m0_gnt    = grant & ~winner;
    assign m1_gnt    = grant & winner;
    assign m0_rvalid = (state == RESP) & ~owner & rst_n;
    assign m1_rvalid = (state == RESP) & owner & rst_n;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

    // rst_n gates the write strobe combinationally so a reset arriving during
    // BUSY prevents the write from committing at that clock edge.
    assign mem_we    = (state == BUSY) & lat_we & rst_n;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule
